// File: rtl/nf_i_fu_pf.sv
// Instruction fetch unit with a prefetch FIFO. Words are requested ahead of decode, and
// a redirect (pc_src) drains the FIFO and restarts fetching at pc_branch.
module nf_i_fu_pf #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          resetn,
  output logic                          req_i,
  output logic [31:0]                   addr_i,
  input  logic                          req_ack_i,
  input  logic [31:0]                   rdata_i,
  output logic [31:0]                   instr_if,
  output logic [31:0]                   pc_if,
  output logic                          valid_if,
  input  logic [31:0]                   pc_branch,
  input  logic                          pc_src,
  input  logic                          stall_if,
  output logic                          flush_id,
  output logic [$clog2(FIFO_DEPTH):0]   fill_lvl
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FIFO_DEPTH);

  logic [31:0]      fpc_q, fpc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             flush_delayed_q, flush_delayed_d;
  logic             first_cycle_q, first_cycle_d;

  logic [31:0]      pc_mem    [FIFO_DEPTH];
  logic [31:0]      instr_mem [FIFO_DEPTH];

  logic             push;
  logic             pop;

  // Request is gated by resetn so that it stays low while reset is held
  assign req_i    = resetn & (fill_q < FULL_LVL) & ~pc_src;
  assign addr_i   = fpc_q;
  assign valid_if = (fill_q != '0);
  assign fill_lvl = fill_q;
  assign pc_if    = pc_mem[head_q];
  assign instr_if = instr_mem[head_q];
  assign flush_id = ~valid_if | pc_src | flush_delayed_q | first_cycle_q;

  assign push = req_i & req_ack_i;
  assign pop  = valid_if & ~stall_if;

  // Next-state logic: a redirect overrides any push or pop in the same cycle
  always_comb begin
    fpc_d           = fpc_q;
    head_d          = head_q;
    tail_d          = tail_q;
    fill_d          = fill_q;
    flush_delayed_d = pc_src;
    first_cycle_d   = 1'b0;
    if (pc_src) begin
      fpc_d  = pc_branch;
      head_d = '0;
      tail_d = '0;
      fill_d = '0;
    end else begin
      if (push) begin
        fpc_d  = fpc_q + 32'd4;
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   fill_d = fill_q + CNT_W'(1);
        2'b01:   fill_d = fill_q - CNT_W'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fpc_q           <= RESET_PC;
      head_q          <= '0;
      tail_q          <= '0;
      fill_q          <= '0;
      flush_delayed_q <= 1'b0;
      first_cycle_q   <= 1'b1;
    end else begin
      fpc_q           <= fpc_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      fill_q          <= fill_d;
      flush_delayed_q <= flush_delayed_d;
      first_cycle_q   <= first_cycle_d;
    end
  end

  // Buffer storage needs no reset; fill_q decides what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]    <= fpc_q;
      instr_mem[tail_q] <= rdata_i;
    end
  end

endmodule

// File: tb/tb_nf_i_fu_pf.sv
// Directed bench for nf_i_fu_pf. The instruction memory is modelled as rdata = addr ^ KEY.
module tb_nf_i_fu_pf;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        clk;
  logic        resetn;
  logic        req_i;
  logic [31:0] addr_i;
  logic        req_ack_i;
  logic [31:0] rdata_i;
  logic [31:0] instr_if;
  logic [31:0] pc_if;
  logic        valid_if;
  logic [31:0] pc_branch;
  logic        pc_src;
  logic        stall_if;
  logic        flush_id;
  logic [2:0]  fill_lvl;

  int checks;
  int failures;

  nf_i_fu_pf #(.FIFO_DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_i     (req_i),
    .addr_i    (addr_i),
    .req_ack_i (req_ack_i),
    .rdata_i   (rdata_i),
    .instr_if  (instr_if),
    .pc_if     (pc_if),
    .valid_if  (valid_if),
    .pc_branch (pc_branch),
    .pc_src    (pc_src),
    .stall_if  (stall_if),
    .flush_id  (flush_id),
    .fill_lvl  (fill_lvl)
  );

  assign rdata_i = addr_i ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs mid-cycle and let combinational outputs settle before sampling
  task automatic drive(input logic ack, input logic stall, input logic src, input logic [31:0] br);
    req_ack_i = ack;
    stall_if  = stall;
    pc_src    = src;
    pc_branch = br;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    req_ack_i = 1'b0; stall_if = 1'b0; pc_src = 1'b0; pc_branch = '0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (req_i !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", req_i); end
    checks++; if (valid_if !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_if); end
    checks++; if (flush_id !== 1'b1) begin failures++; $display("FAIL reset_flush got=%b exp=1", flush_id); end
    checks++; if (fill_lvl !== 3'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill_lvl); end
    checks++; if (addr_i !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", addr_i); end
  endtask

  // Continuous acks, no stall: one fetch per cycle, one cycle latency to head
  task automatic test_stream();
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (addr_i !== 32'(4*k)) begin failures++; $display("FAIL stream_addr cyc=%0d got=%h exp=%h", k, addr_i, 32'(4*k)); end
      checks++; if (req_i !== 1'b1) begin failures++; $display("FAIL stream_req cyc=%0d got=%b exp=1", k, req_i); end
      if (k == 0) begin
        checks++; if (valid_if !== 1'b0) begin failures++; $display("FAIL stream_valid0 got=%b exp=0", valid_if); end
        checks++; if (flush_id !== 1'b1) begin failures++; $display("FAIL stream_flush0 got=%b exp=1", flush_id); end
      end else begin
        checks++; if (valid_if !== 1'b1) begin failures++; $display("FAIL stream_valid cyc=%0d got=%b exp=1", k, valid_if); end
        checks++; if (pc_if !== 32'(4*(k-1))) begin failures++; $display("FAIL stream_pc cyc=%0d got=%h exp=%h", k, pc_if, 32'(4*(k-1))); end
        checks++; if (instr_if !== (32'(4*(k-1)) ^ KEY)) begin failures++; $display("FAIL stream_instr cyc=%0d got=%h exp=%h", k, instr_if, 32'(4*(k-1)) ^ KEY); end
        checks++; if (flush_id !== 1'b0) begin failures++; $display("FAIL stream_flush cyc=%0d got=%b exp=0", k, flush_id); end
        checks++; if (fill_lvl !== 3'd1) begin failures++; $display("FAIL stream_fill cyc=%0d got=%0d exp=1", k, fill_lvl); end
      end
      @(negedge clk);
    end
  endtask

  // Stall fills the buffer to capacity, then releasing it drains in order
  task automatic test_stall_fill();
    logic [2:0]  exp_fill [4];
    logic [31:0] exp_pc   [4];
    exp_fill = '{3'd4, 3'd3, 3'd3, 3'd3};
    exp_pc   = '{32'd0, 32'd4, 32'd8, 32'd12};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      checks++; if (fill_lvl !== 3'(k)) begin failures++; $display("FAIL stall_fill cyc=%0d got=%0d exp=%0d", k, fill_lvl, k); end
      checks++; if (req_i !== (k < 4)) begin failures++; $display("FAIL stall_req cyc=%0d got=%b exp=%b", k, req_i, k < 4); end
      if (k > 0) begin
        checks++; if (pc_if !== 32'h0) begin failures++; $display("FAIL stall_pc cyc=%0d got=%h exp=0", k, pc_if); end
      end
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (pc_if !== exp_pc[k]) begin failures++; $display("FAIL drain_pc idx=%0d got=%h exp=%h", k, pc_if, exp_pc[k]); end
      checks++; if (valid_if !== 1'b1) begin failures++; $display("FAIL drain_valid idx=%0d got=%b exp=1", k, valid_if); end
      checks++; if (fill_lvl !== exp_fill[k]) begin failures++; $display("FAIL drain_fill idx=%0d got=%0d exp=%0d", k, fill_lvl, exp_fill[k]); end
      @(negedge clk);
    end
  endtask

  // Redirect during stall with three entries buffered
  task automatic test_redirect();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
    end
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    checks++; if (fill_lvl !== 3'd3) begin failures++; $display("FAIL redir_pre_fill got=%0d exp=3", fill_lvl); end
    checks++; if (flush_id !== 1'b1) begin failures++; $display("FAIL redir_strobe_flush got=%b exp=1", flush_id); end
    checks++; if (req_i !== 1'b0) begin failures++; $display("FAIL redir_strobe_req got=%b exp=0", req_i); end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (fill_lvl !== 3'd0) begin failures++; $display("FAIL redir_fill got=%0d exp=0", fill_lvl); end
    checks++; if (addr_i !== 32'h100) begin failures++; $display("FAIL redir_addr got=%h exp=100", addr_i); end
    checks++; if (flush_id !== 1'b1) begin failures++; $display("FAIL redir_next_flush got=%b exp=1", flush_id); end
    checks++; if (valid_if !== 1'b0) begin failures++; $display("FAIL redir_next_valid got=%b exp=0", valid_if); end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (valid_if !== 1'b1) begin failures++; $display("FAIL redir_first_valid got=%b exp=1", valid_if); end
    checks++; if (pc_if !== 32'h100) begin failures++; $display("FAIL redir_first_pc got=%h exp=100", pc_if); end
    checks++; if (instr_if !== (32'h100 ^ KEY)) begin failures++; $display("FAIL redir_first_instr got=%h exp=%h", instr_if, 32'h100 ^ KEY); end
    checks++; if (flush_id !== 1'b0) begin failures++; $display("FAIL redir_after_flush got=%b exp=0", flush_id); end
    @(negedge clk);
  endtask

  // Memory withholding acks leaves the buffer empty and the address parked
  task automatic test_no_ack();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      checks++; if (valid_if !== 1'b0) begin failures++; $display("FAIL noack_valid cyc=%0d got=%b exp=0", k, valid_if); end
      checks++; if (flush_id !== 1'b1) begin failures++; $display("FAIL noack_flush cyc=%0d got=%b exp=1", k, flush_id); end
      checks++; if (addr_i !== 32'h0) begin failures++; $display("FAIL noack_addr cyc=%0d got=%h exp=0", k, addr_i); end
      @(negedge clk);
    end
  endtask

  // Fetch pointer wraps from the top of the address space to zero
  task automatic test_wrap();
    logic [31:0] exp_addr [3];
    exp_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    apply_reset();
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (addr_i !== exp_addr[k]) begin failures++; $display("FAIL wrap_addr idx=%0d got=%h exp=%h", k, addr_i, exp_addr[k]); end
      if (k > 0) begin
        checks++; if (pc_if !== exp_addr[k-1]) begin failures++; $display("FAIL wrap_pc idx=%0d got=%h exp=%h", k, pc_if, exp_addr[k-1]); end
      end
      @(negedge clk);
    end
  endtask

  // Asynchronous reset with two entries buffered discards them
  task automatic test_mid_reset();
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (fill_lvl !== 3'd2) begin failures++; $display("FAIL midrst_pre_fill got=%0d exp=2", fill_lvl); end
    resetn = 1'b0;
    #1;
    checks++; if (fill_lvl !== 3'd0) begin failures++; $display("FAIL midrst_fill got=%0d exp=0", fill_lvl); end
    checks++; if (valid_if !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", valid_if); end
    checks++; if (req_i !== 1'b0) begin failures++; $display("FAIL midrst_req got=%b exp=0", req_i); end
    checks++; if (flush_id !== 1'b1) begin failures++; $display("FAIL midrst_flush got=%b exp=1", flush_id); end
    checks++; if (addr_i !== 32'h8) begin
      if (addr_i !== 32'h0) begin failures++; $display("FAIL midrst_addr got=%h exp=0", addr_i); end
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      checks++; if (valid_if !== 1'b0) begin failures++; $display("FAIL postrst_valid cyc=%0d got=%b exp=0", k, valid_if); end
      checks++; if (addr_i !== 32'h0) begin failures++; $display("FAIL postrst_addr cyc=%0d got=%h exp=0", k, addr_i); end
      @(negedge clk);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (valid_if !== 1'b1) begin failures++; $display("FAIL postrst_first_valid got=%b exp=1", valid_if); end
    checks++; if (pc_if !== 32'h0) begin failures++; $display("FAIL postrst_first_pc got=%h exp=0", pc_if); end
    checks++; if (fill_lvl !== 3'd1) begin failures++; $display("FAIL postrst_fill got=%0d exp=1", fill_lvl); end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    resetn = 1'b0;
    req_ack_i = 1'b0;
    stall_if = 1'b0;
    pc_src = 1'b0;
    pc_branch = '0;
    test_reset();
    test_stream();
    test_stall_fill();
    test_redirect();
    test_no_ack();
    test_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
